// File: rtl/execute_unit.sv
// MIPS R-type execute stage: single-cycle ALU/shift/HI-LO moves plus a
// 32-step iterative multiplier/divider that writes the HI/LO pair.
module execute_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] instr,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  output logic        ready,
  output logic        regWrite,
  output logic [4:0]  wr_addr,
  output logic [31:0] dataWrite,
  output logic        overflow,
  output logic        illegal,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12,
                         F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                         F_DIV  = 6'h1A, F_DIVU = 6'h1B, F_ADD  = 6'h20,
                         F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
                         F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
                         F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_prod_q, neg_prod_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] data_write_q, data_write_d;
  logic        overflow_q, overflow_d;
  logic        illegal_q, illegal_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rd, shamt;
  logic        unused_rs_rt;
  assign opcode       = instr[31:26];
  assign rd           = instr[15:11];
  assign shamt        = instr[10:6];
  assign funct        = instr[5:0];
  assign unused_rs_rt = ^instr[25:16];

  logic [31:0] add_res, sub_res, a_mag, b_mag;
  logic        is_signed;
  assign add_res   = reg1 + reg2;
  assign sub_res   = reg1 - reg2;
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign a_mag     = (is_signed && reg1[31]) ? -reg1 : reg1;
  assign b_mag     = (is_signed && reg2[31]) ? -reg2 : reg2;

  // One iteration of shift-add multiply / restoring divide on unsigned magnitudes;
  // signs are reapplied when the last step retires.
  logic [32:0] mul_sum, div_sh, div_diff;
  logic [63:0] mul_next, div_next, step, prod;
  logic [31:0] quo, rem;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign div_sh   = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_next = div_diff[32] ? {div_sh[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
  assign step     = (state_q == S_MUL) ? mul_next : div_next;
  assign prod     = neg_prod_q ? -step : step;
  assign quo      = neg_prod_q ? -step[31:0] : step[31:0];
  assign rem      = neg_rem_q ? -step[63:32] : step[63:32];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    acc_d        = acc_q;
    opb_d        = opb_q;
    cnt_d        = cnt_q;
    neg_prod_d   = neg_prod_q;
    neg_rem_d    = neg_rem_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    reg_write_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    data_write_d = data_write_q;
    overflow_d   = 1'b0;
    illegal_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          wr_addr_d    = rd;
          data_write_d = 32'd0;
          if (opcode != 6'd0) begin
            illegal_d = 1'b1;
          end else begin
            unique case (funct)
              F_ADD: begin
                data_write_d = add_res;
                overflow_d   = (reg1[31] == reg2[31]) && (add_res[31] != reg1[31]);
                reg_write_d  = !overflow_d;
              end
              F_SUB: begin
                data_write_d = sub_res;
                overflow_d   = (reg1[31] != reg2[31]) && (sub_res[31] != reg1[31]);
                reg_write_d  = !overflow_d;
              end
              F_ADDU: begin data_write_d = add_res;        reg_write_d = 1'b1; end
              F_SUBU: begin data_write_d = sub_res;        reg_write_d = 1'b1; end
              F_AND:  begin data_write_d = reg1 & reg2;    reg_write_d = 1'b1; end
              F_OR:   begin data_write_d = reg1 | reg2;    reg_write_d = 1'b1; end
              F_XOR:  begin data_write_d = reg1 ^ reg2;    reg_write_d = 1'b1; end
              F_NOR:  begin data_write_d = ~(reg1 | reg2); reg_write_d = 1'b1; end
              F_SLT: begin
                data_write_d = {31'd0, $signed(reg1) < $signed(reg2)};
                reg_write_d  = 1'b1;
              end
              F_SLTU: begin data_write_d = {31'd0, reg1 < reg2}; reg_write_d = 1'b1; end
              F_SLL:  begin data_write_d = reg2 << shamt;  reg_write_d = 1'b1; end
              F_SRL:  begin data_write_d = reg2 >> shamt;  reg_write_d = 1'b1; end
              F_SRA: begin
                data_write_d = 32'($signed(reg2) >>> shamt);
                reg_write_d  = 1'b1;
              end
              F_MFHI: begin data_write_d = hi_q; reg_write_d = 1'b1; end
              F_MFLO: begin data_write_d = lo_q; reg_write_d = 1'b1; end
              F_MTHI: hi_d = reg1;
              F_MTLO: lo_d = reg1;
              F_MULT, F_MULTU: begin
                state_d    = S_MUL;
                acc_d      = {32'd0, b_mag};
                opb_d      = a_mag;
                cnt_d      = 5'd0;
                neg_prod_d = is_signed && (reg1[31] ^ reg2[31]);
                neg_rem_d  = 1'b0;
              end
              F_DIV, F_DIVU: begin
                // Quotient sign is not applied on divide-by-zero so LO stays all ones.
                state_d    = S_DIV;
                acc_d      = {32'd0, a_mag};
                opb_d      = b_mag;
                cnt_d      = 5'd0;
                neg_prod_d = is_signed && (reg1[31] ^ reg2[31]) && (reg2 != 32'd0);
                neg_rem_d  = is_signed && reg1[31];
              end
              default: illegal_d = 1'b1;
            endcase
          end
          reg_write_d = reg_write_d && (rd != 5'd0);
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_IDLE;
          if (state_q == S_MUL) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= 64'd0;
      opb_q        <= 32'd0;
      cnt_q        <= 5'd0;
      neg_prod_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      reg_write_q  <= 1'b0;
      wr_addr_q    <= 5'd0;
      data_write_q <= 32'd0;
      overflow_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      cnt_q        <= cnt_d;
      neg_prod_q   <= neg_prod_d;
      neg_rem_q    <= neg_rem_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      reg_write_q  <= reg_write_d;
      wr_addr_q    <= wr_addr_d;
      data_write_q <= data_write_d;
      overflow_q   <= overflow_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign regWrite  = reg_write_q;
  assign wr_addr   = wr_addr_q;
  assign dataWrite = data_write_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: hand-computed vectors for ALU ops,
// exceptions, HI/LO moves, iterative mult/div timing and reset abort.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] reg1 = 32'd0;
  logic [31:0] reg2 = 32'd0;
  logic        ready, regWrite, overflow, illegal;
  logic [4:0]  wr_addr;
  logic [31:0] dataWrite, hi, lo;

  int checks = 0;
  int errors = 0;

  execute_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr(instr),
    .reg1(reg1), .reg2(reg2), .ready(ready), .regWrite(regWrite),
    .wr_addr(wr_addr), .dataWrite(dataWrite), .overflow(overflow),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {op, 5'd1, 5'd2, rd, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction for the next edge, then sample 1 time unit after it.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    valid_in = 1'b1;
    instr    = ins;
    reg1     = a;
    reg2     = b;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Hold a disruptive MTHI with new operands while busy; count edges until ready.
  task automatic wait_ready(output int n);
    n        = 0;
    valid_in = 1'b1;
    instr    = mk(6'h00, 5'd3, 5'd0, 6'h11);
    reg1     = 32'h1357_9BDF;
    reg2     = 32'h0000_0005;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    valid_in = 1'b0;
  endtask

  int n;

  initial begin
    // Reset with a pending MTHI: reset must win.
    rst = 1'b1; valid_in = 1'b1; instr = mk(6'h00, 5'd0, 5'd0, 6'h11); reg1 = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    check("rst_regWrite", {31'd0, regWrite}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_dataWrite", dataWrite, 32'd0);
    check("rst_ovf_ill", {30'd0, overflow, illegal}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);

    issue(mk(6'h00, 5'd5, 5'd0, 6'h20), 32'd3, 32'd4);
    check("add_we", {31'd0, regWrite}, 32'd1);
    check("add_addr", {27'd0, wr_addr}, 32'd5);
    check("add_data", dataWrite, 32'd7);
    idle();
    check("add_we_pulse", {31'd0, regWrite}, 32'd0);

    issue(mk(6'h00, 5'd6, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'd1);
    check("add_ovf", {31'd0, overflow}, 32'd1);
    check("add_ovf_we", {31'd0, regWrite}, 32'd0);
    issue(mk(6'h00, 5'd6, 5'd0, 6'h21), 32'h7FFF_FFFF, 32'd1);
    check("addu_data", dataWrite, 32'h8000_0000);
    check("addu_we_ovf", {30'd0, regWrite, overflow}, 32'd2);
    issue(mk(6'h00, 5'd7, 5'd0, 6'h22), 32'd10, 32'd3);
    check("sub_data", dataWrite, 32'd7);
    issue(mk(6'h00, 5'd7, 5'd0, 6'h22), 32'h8000_0000, 32'd1);
    check("sub_ovf_we", {30'd0, regWrite, overflow}, 32'd1);
    issue(mk(6'h00, 5'd7, 5'd0, 6'h23), 32'd0, 32'd1);
    check("subu_data", dataWrite, 32'hFFFF_FFFF);

    // Back-to-back logic ops, one per cycle.
    issue(mk(6'h00, 5'd8, 5'd0, 6'h24), 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("and_data", dataWrite, 32'h00F0_000F);
    issue(mk(6'h00, 5'd9, 5'd0, 6'h25), 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("or_data", dataWrite, 32'hFFF0_0FFF);
    check("or_addr_we", {26'd0, wr_addr, regWrite}, {26'd0, 5'd9, 1'b1});
    issue(mk(6'h00, 5'd10, 5'd0, 6'h26), 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("xor_data", dataWrite, 32'hFF00_0FF0);
    issue(mk(6'h00, 5'd11, 5'd0, 6'h27), 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("nor_data", dataWrite, 32'h000F_F000);

    issue(mk(6'h00, 5'd12, 5'd4, 6'h03), 32'd0, 32'h8000_0000);
    check("sra_data", dataWrite, 32'hF800_0000);
    issue(mk(6'h00, 5'd12, 5'd4, 6'h02), 32'd0, 32'h8000_0000);
    check("srl_data", dataWrite, 32'h0800_0000);
    issue(mk(6'h00, 5'd12, 5'd8, 6'h00), 32'd0, 32'h0000_00AB);
    check("sll_data", dataWrite, 32'h0000_AB00);
    issue(mk(6'h00, 5'd13, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1);
    check("slt_data", dataWrite, 32'd1);
    issue(mk(6'h00, 5'd13, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'd1);
    check("sltu_data", dataWrite, 32'd0);

    issue(mk(6'h00, 5'd0, 5'd0, 6'h20), 32'd1, 32'd2);
    check("rd0_we", {31'd0, regWrite}, 32'd0);
    check("rd0_data", dataWrite, 32'd3);

    issue(mk(6'h00, 5'd0, 5'd0, 6'h11), 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    issue(mk(6'h00, 5'd0, 5'd0, 6'h13), 32'h0000_5678, 32'd0);
    check("mtlo_lo", lo, 32'h0000_5678);
    issue(mk(6'h00, 5'd14, 5'd0, 6'h10), 32'd0, 32'd0);
    check("mfhi_data", dataWrite, 32'h0000_1234);
    issue(mk(6'h00, 5'd14, 5'd0, 6'h12), 32'd0, 32'd0);
    check("mflo_data", dataWrite, 32'h0000_5678);

    issue(mk(6'h00, 5'd15, 5'd0, 6'h18), 32'hFFFF_FFFE, 32'd3);
    check("mult_busy", {30'd0, ready, regWrite}, 32'd0);
    wait_ready(n);
    check("mult_cycles", n, 32'd32);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    idle();
    check("mult_no_late_mthi", hi, 32'hFFFF_FFFF);

    issue(mk(6'h00, 5'd0, 5'd0, 6'h19), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready(n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    issue(mk(6'h00, 5'd0, 5'd0, 6'h1A), 32'hFFFF_FFF9, 32'd2);
    wait_ready(n);
    check("div_cycles", n, 32'd32);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(mk(6'h00, 5'd0, 5'd0, 6'h1B), 32'd7, 32'd0);
    wait_ready(n);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);
    check("divu0_no_exc", {30'd0, overflow, illegal}, 32'd0);
    issue(mk(6'h00, 5'd0, 5'd0, 6'h1A), 32'hFFFF_FFF9, 32'd0);
    wait_ready(n);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFF9);
    issue(mk(6'h00, 5'd0, 5'd0, 6'h1A), 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(n);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'd0);
    issue(mk(6'h00, 5'd0, 5'd0, 6'h1B), 32'd100, 32'd7);
    wait_ready(n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Reset at cycle 10 of a DIVU aborts it.
    issue(mk(6'h00, 5'd0, 5'd0, 6'h1B), 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_update", hi | lo, 32'd0);

    issue(mk(6'h08, 5'd5, 5'd0, 6'h20), 32'd3, 32'd4);
    check("op08_illegal", {31'd0, illegal}, 32'd1);
    check("op08_we", {31'd0, regWrite}, 32'd0);
    issue(mk(6'h00, 5'd5, 5'd0, 6'h3F), 32'd3, 32'd4);
    check("funct3f_ill_we", {30'd0, illegal, regWrite}, 32'd2);
    issue(mk(6'h01, 5'd0, 5'd0, 6'h11), 32'h0000_ABCD, 32'd0);
    check("ill_mthi_hi", hi, 32'd0);
    idle();
    check("ill_pulse", {31'd0, illegal}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
